// File: rtl/fpu_align_stage_if.sv
// Operand/result handshake bundle for fpu_align_stage.
// master = upstream producer + downstream consumer side, slave = the align stage.
interface fpu_align_stage_if;
  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 27;
  localparam int unsigned CLS_W = 8;
  localparam int unsigned SEL_W = 2;

  logic               in_valid;
  logic               in_ready;
  logic [FP_W-1:0]    in_a;
  logic [FP_W-1:0]    in_b;
  logic [SEL_W-1:0]   in_sel;

  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_sel;
  logic               out_swap;
  logic               out_sign_x;
  logic               out_sign_y;
  logic [EXP_W-1:0]   out_exp_x;
  logic [EXP_W-1:0]   out_exp_y;
  logic [MAN_W-1:0]   out_man_x;
  logic [MAN_W-1:0]   out_man_y;
  logic [CLS_W-1:0]   out_cls;

  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_sel, out_swap, out_sign_x, out_sign_y,
           out_exp_x, out_exp_y, out_man_x, out_man_y, out_cls
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_sel, out_swap, out_sign_x, out_sign_y,
           out_exp_x, out_exp_y, out_man_x, out_man_y, out_cls
  );
endinterface

// File: rtl/fpu_align_stage.sv
// FPU front stage: unpack, classify, order and align two single-precision operands
// behind a 2-entry skid buffer. Define FPU_DENORM_EN to keep denormals (else flush to zero).
module fpu_align_stage (
  input  logic               clk,
  input  logic               rst,
  fpu_align_stage_if.slave   io
);
  localparam int unsigned FP_W   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MAN_W  = 27;
  localparam int unsigned CLS_W  = 8;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_SUB = 2'b01;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W-1:0]  man;
    logic              nan;
    logic              inf;
    logic              zero;
    logic              den;
  } op_t;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              swap;
    logic              sign_x;
    logic              sign_y;
    logic [EXP_W-1:0]  exp_x;
    logic [EXP_W-1:0]  exp_y;
    logic [MAN_W-1:0]  man_x;
    logic [MAN_W-1:0]  man_y;
    logic [CLS_W-1:0]  cls;
  } beat_t;

  // Unpack one IEEE-754 single into sign / effective exponent / {hidden, frac, GRS} + class.
  function automatic op_t unpack_op(input logic [FP_W-1:0] f);
    op_t  o;
    logic exp_max;
    logic exp_zero;
    logic frac_nz;
    exp_max  = &f[FP_W-2 -: EXP_W];
    exp_zero = ~|f[FP_W-2 -: EXP_W];
    frac_nz  = |f[FRAC_W-1:0];
    o        = '0;
    o.sign   = f[FP_W-1];
    o.nan    = exp_max & frac_nz;
    o.inf    = exp_max & ~frac_nz;
    o.den    = exp_zero & frac_nz;
`ifdef FPU_DENORM_EN
    o.zero   = exp_zero & ~frac_nz;
    o.exp    = (exp_zero & frac_nz) ? EXP_W'(1) : f[FP_W-2 -: EXP_W];
    o.man    = {~exp_zero, f[FRAC_W-1:0], 3'b000};
`else
    o.zero   = exp_zero;
    o.exp    = f[FP_W-2 -: EXP_W];
    o.man    = exp_zero ? '0 : {1'b1, f[FRAC_W-1:0], 3'b000};
`endif
    return o;
  endfunction

  op_t               w_op_a;
  op_t               w_op_b;
  op_t               w_op_b_s;
  op_t               w_x;
  op_t               w_y;
  logic              w_swap;
  logic [EXP_W-1:0]  w_d;
  logic              w_far;
  logic [MAN_W-1:0]  w_shifted;
  logic [MAN_W-1:0]  w_lost_mask;
  logic              w_sticky;
  logic [MAN_W-1:0]  w_man_y_al;
  logic [MAN_W-1:0]  w_man_y;
  beat_t             w_beat;

  assign w_op_a = unpack_op(io.in_a);
  assign w_op_b = unpack_op(io.in_b);

  // Subtraction becomes addition of -B before the operands are ordered.
  always_comb begin
    w_op_b_s      = w_op_b;
    w_op_b_s.sign = w_op_b.sign ^ (io.in_sel == SEL_SUB);
  end

  // Add/sub put the larger magnitude in X; mul/div keep A/B order.
  assign w_swap = ~io.in_sel[1] & (io.in_b[FP_W-2:0] > io.in_a[FP_W-2:0]);
  assign w_x    = w_swap ? w_op_b_s : w_op_a;
  assign w_y    = w_swap ? w_op_a   : w_op_b_s;

  assign w_d         = w_x.exp - w_y.exp;
  assign w_far       = (w_d >= EXP_W'(MAN_W));
  assign w_shifted   = w_y.man >> w_d;
  assign w_lost_mask = ~({MAN_W{1'b1}} << w_d);
  assign w_sticky    = |(w_y.man & w_lost_mask);
  assign w_man_y_al  = w_far ? {{(MAN_W-1){1'b0}}, |w_y.man}
                             : {w_shifted[MAN_W-1:1], w_shifted[0] | w_sticky};
  assign w_man_y     = io.in_sel[1] ? w_y.man : w_man_y_al;

  always_comb begin
    w_beat        = '0;
    w_beat.sel    = io.in_sel;
    w_beat.swap   = w_swap;
    w_beat.sign_x = w_x.sign;
    w_beat.sign_y = w_y.sign;
    w_beat.exp_x  = w_x.exp;
    w_beat.exp_y  = w_y.exp;
    w_beat.man_x  = w_x.man;
    w_beat.man_y  = w_man_y;
    w_beat.cls    = {w_op_a.nan, w_op_a.inf, w_op_a.zero, w_op_a.den,
                     w_op_b.nan, w_op_b.inf, w_op_b.zero, w_op_b.den};
  end

  beat_t r_main;
  beat_t r_skid;
  logic  r_main_valid;
  logic  r_skid_valid;

  beat_t w_main_nxt;
  beat_t w_skid_nxt;
  logic  w_main_valid_nxt;
  logic  w_skid_valid_nxt;
  logic  w_drain;
  logic  w_accept;

  assign w_drain  = r_main_valid & io.out_ready;
  assign w_accept = io.in_valid & ~r_skid_valid;

  // Skid buffer: main refills from skid first, then from the input; otherwise input parks in skid.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_nxt       = w_beat;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_beat;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  assign io.in_ready   = ~r_skid_valid;
  assign io.out_valid  = r_main_valid;
  assign io.out_sel    = r_main.sel;
  assign io.out_swap   = r_main.swap;
  assign io.out_sign_x = r_main.sign_x;
  assign io.out_sign_y = r_main.sign_y;
  assign io.out_exp_x  = r_main.exp_x;
  assign io.out_exp_y  = r_main.exp_y;
  assign io.out_man_x  = r_main.man_x;
  assign io.out_man_y  = r_main.man_y;
  assign io.out_cls    = r_main.cls;

endmodule

// File: doc/fpu_align_stage.md
FPU_ALIGN_STAGE -- requirements
Module: fpu_align_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state; rst input 1, synchronous active-high reset.
REQ-002 It SHALL have these handshake ports: in_valid input 1, operand beat present; in_ready output 1, beat accepted at a clk edge when in_valid&&in_ready.
REQ-003 It SHALL have these operand ports: in_a input 32, IEEE-754 single operand A; in_b input 32, operand B; in_sel input 2, op select: 00 add, 01 sub, 10 mul, 11 div.
REQ-004 It SHALL have these output handshake ports: out_valid output 1, result beat present; out_ready input 1, downstream accepts when out_valid&&out_ready.
REQ-005 It SHALL have these result ports:
- out_sel output 2, registered in_sel.
- out_swap output 1, X is B.
- out_sign_x / out_sign_y output 1 each.
- out_exp_x / out_exp_y output 8 each, biased exponents.
- out_man_x / out_man_y output 27 each, {hidden, frac[22:0], G, R, S}.
- out_cls output 8, {a_nan, a_inf, a_zero, a_den, b_nan, b_inf, b_zero, b_den}.

Function
REQ-006 The block SHALL unpack each operand: man = {hidden, frac, 3'b000}; hidden = (exp != 0).
REQ-007 Classification SHALL be: nan = exp 0xFF and frac != 0; inf = exp 0xFF and frac 0; zero = exp 0 and frac 0; den = exp 0 and frac != 0.
REQ-008 For sub (01), the sign of B SHALL be inverted before any swap; add and sub are otherwise identical.
REQ-009 For add/sub, X SHALL be the operand with the larger {exp, frac}; on a tie X = A and out_swap = 0.
REQ-010 For add/sub, out_man_y SHALL be man_y shifted right by d = exp_x - exp_y, with bit0 ORed with every bit shifted out (sticky).
REQ-011 For d >= 27 the block SHALL set out_man_y = 27'h1 when man_y != 0, and 0 otherwise.
REQ-012 For mul/div, X SHALL be A and Y SHALL be B with out_swap = 0, and mantissas SHALL be unshifted.
REQ-013 The output SHALL be a two-entry skid buffer (main + skid register); in_ready SHALL equal !skid_valid, driven from a register.
REQ-014 Latency SHALL be 1 cycle: a beat accepted at edge N while main is empty or draining SHALL appear on the outputs with out_valid = 1 from edge N.
REQ-015 Buffer transfers SHALL be:
- If main is valid and not draining, an accepted beat SHALL go to skid.
- When main drains and skid is valid, skid SHALL move to main on the same edge.
REQ-016 A simultaneous drain and accept SHALL sustain throughput of 1 beat/clk.
REQ-017 Beats SHALL leave in acceptance order, and none SHALL be dropped or duplicated.
REQ-018 While out_valid && !out_ready, all out_* SHALL hold stable.

Reset
REQ-019 On rst at a clk edge, the main and skid valid flags SHALL clear: out_valid = 0 and in_ready = 1 from the next cycle.
REQ-020 On rst, all out_* data fields SHALL clear to 0, including any reset arriving mid-stall with both entries full.
REQ-021 During rst, in_valid SHALL be ignored.

Configuration
REQ-022 The macro FPU_DENORM_EN SHALL control denormal handling.
REQ-023 With FPU_DENORM_EN defined, a denormal SHALL be unpacked with hidden = 0 and effective exponent 1 (out_exp = 1), and its den class bit set.
REQ-024 Without FPU_DENORM_EN, a denormal SHALL be flushed to signed zero: man 0, exp 0, zero bit set, den bit still set.

Verification
REQ-025 Basic add: A=0x3F800000, B=0x40000000, sel=00 -> out_swap=1, exp_x=0x80, exp_y=0x7F, man_x=0x4000000, man_y=0x2000000, out_valid 1 cycle after accept.
REQ-026 Alignment with sticky and saturation:
- A=0x3F800001, B=0x4C000000, sel=00 -> d=25, man_y=0x0000003 (sticky set).
- A=0x4E000000, B=0x3F800000 -> d=29, man_y=0x0000001.
REQ-027 Sub with tie: A=B=0x3F800000, sel=01 -> swap=0, sign_x=0, sign_y=1, man_y=man_x=0x4000000.
REQ-028 Backpressure: hold out_ready=0 and offer 3 beats -> beats 1 and 2 accepted, in_ready=0 after beat 2; release out_ready -> outputs in order 1, 2, 3 on consecutive cycles.
REQ-029 Classes and denormals:
- A=0x7FC00000, B=0x00000001, sel=10 -> cls[7]=1, cls[0]=1.
- With FPU_DENORM_EN: man_y=0x0000008, exp_y=1.
- Without FPU_DENORM_EN: man_y=0, cls[1]=1.
REQ-030 Reset mid-stall: both entries full, pulse rst -> next cycle out_valid=0, in_ready=1, all data fields 0.
